reg_select_sequencer: RTL and testbench

//  Control sequencer for the 4-bit CPU. Produces the 2-bit register-enable code {D1,D0}
//  (00 Reg_A, 01 Reg_B, 10 Reg_0/out, 11 none) that drives the register-enable decoder.

---
 rtl/reg_select_sequencer_pkg.sv | 48 ++++
 rtl/reg_select_sequencer_opcode_field_decode.sv | 34 +++
 rtl/reg_select_sequencer.sv | 116 +++++++++++
 tb/tb_reg_select_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_select_sequencer_pkg.sv
// reg_select_sequencer_pkg: shared opcodes, enable/source codes, FSM states and decode record
// Optional feature macro: JMP_INSTR_EN (adds JMP/JNC opcodes in the decoder).
package reg_select_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_e;

    localparam logic [1:0] DEST_A    = 2'b00;
    localparam logic [1:0] DEST_B    = 2'b01;
    localparam logic [1:0] DEST_OUT  = 2'b10;
    localparam logic [1:0] DEST_NONE = 2'b11;

    localparam logic [1:0] SRC_A    = 2'b00;
    localparam logic [1:0] SRC_B    = 2'b01;
    localparam logic [1:0] SRC_IN   = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    localparam logic [3:0] OP_ADD_A_IM = 4'h0;
    localparam logic [3:0] OP_MOV_A_B  = 4'h1;
    localparam logic [3:0] OP_IN_A     = 4'h2;
    localparam logic [3:0] OP_MOV_A_IM = 4'h3;
    localparam logic [3:0] OP_MOV_B_A  = 4'h4;
    localparam logic [3:0] OP_ADD_B_IM = 4'h5;
    localparam logic [3:0] OP_IN_B     = 4'h6;
    localparam logic [3:0] OP_MOV_B_IM = 4'h7;
    localparam logic [3:0] OP_OUT_B    = 4'h9;
    localparam logic [3:0] OP_OUT_IM   = 4'hB;
    localparam logic [3:0] OP_JNC      = 4'hE;
    localparam logic [3:0] OP_JMP      = 4'hF;

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] src;
        logic       is_add;
        logic       is_jmp;
        logic       is_jnc;
    } dec_t;

    function automatic dec_t mk_dec(logic [1:0] dest, logic [1:0] src, logic is_add,
                                    logic is_jmp, logic is_jnc);
        return '{dest: dest, src: src, is_add: is_add, is_jmp: is_jmp, is_jnc: is_jnc};
    endfunction

endpackage

// File: rtl/reg_select_sequencer_opcode_field_decode.sv
// reg_select_sequencer_opcode_field_decode: combinational opcode -> dest/src/add/jump decode
// Ports:
//   opcode_i  in   4      opcode field
//   dec_o     out  dec_t  {dest, src, is_add, is_jmp, is_jnc}
// Macro JMP_INSTR_EN: when defined, E decodes as JNC and F as JMP; otherwise both are NOP.
module reg_select_sequencer_opcode_field_decode
    import reg_select_sequencer_pkg::*;
(
    input  logic [3:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = mk_dec(DEST_NONE, SRC_ZERO, 1'b0, 1'b0, 1'b0);
        case (opcode_i)
            OP_ADD_A_IM: dec_o = mk_dec(DEST_A, SRC_A, 1'b1, 1'b0, 1'b0);
            OP_MOV_A_B:  dec_o = mk_dec(DEST_A, SRC_B, 1'b0, 1'b0, 1'b0);
            OP_IN_A:     dec_o = mk_dec(DEST_A, SRC_IN, 1'b0, 1'b0, 1'b0);
            OP_MOV_A_IM: dec_o = mk_dec(DEST_A, SRC_ZERO, 1'b0, 1'b0, 1'b0);
            OP_MOV_B_A:  dec_o = mk_dec(DEST_B, SRC_A, 1'b0, 1'b0, 1'b0);
            OP_ADD_B_IM: dec_o = mk_dec(DEST_B, SRC_B, 1'b1, 1'b0, 1'b0);
            OP_IN_B:     dec_o = mk_dec(DEST_B, SRC_IN, 1'b0, 1'b0, 1'b0);
            OP_MOV_B_IM: dec_o = mk_dec(DEST_B, SRC_ZERO, 1'b0, 1'b0, 1'b0);
            OP_OUT_B:    dec_o = mk_dec(DEST_OUT, SRC_B, 1'b0, 1'b0, 1'b0);
            OP_OUT_IM:   dec_o = mk_dec(DEST_OUT, SRC_ZERO, 1'b0, 1'b0, 1'b0);
`ifdef JMP_INSTR_EN
            OP_JNC:      dec_o = mk_dec(DEST_NONE, SRC_ZERO, 1'b0, 1'b1, 1'b1);
            OP_JMP:      dec_o = mk_dec(DEST_NONE, SRC_ZERO, 1'b0, 1'b1, 1'b0);
`endif
            default:     dec_o = mk_dec(DEST_NONE, SRC_ZERO, 1'b0, 1'b0, 1'b0);
        endcase
    end

endmodule

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: 4-bit CPU control sequencer (IDLE/FETCH/DECODE/EXEC) emitting {D1,D0}
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high
//   run          in   1       1 = execute program, 0 = stop after current instruction
//   pc_addr      out  PC_W    ROM address (registered PC)
//   fetch_req    out  1       ROM read request, held in FETCH until instr_valid
//   instr        in   8       ROM data {opcode, imm}
//   instr_valid  in   1       ROM data valid (only looked at in FETCH)
//   alu_carry    in   1       datapath carry, captured in EXEC of ADD ops
//   D1, D0       out  1 each  register-enable code, 11 outside EXEC
//   src_sel      out  2       adder A-input select
//   imm          out  DATA_W  immediate of latched instruction
//   busy         out  1       high outside IDLE
// Macro JMP_INSTR_EN: enables JMP (F) and JNC (E); default build always increments PC.
module reg_select_sequencer
    import reg_select_sequencer_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int OPC_W  = 4,
    parameter int DATA_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    output logic [PC_W-1:0]         pc_addr,
    output logic                    fetch_req,
    input  logic [OPC_W+DATA_W-1:0] instr,
    input  logic                    instr_valid,
    input  logic                    alu_carry,
    output logic                    D1,
    output logic                    D0,
    output logic [1:0]              src_sel,
    output logic [DATA_W-1:0]       imm,
    output logic                    busy
);

    state_e                    state_q;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [OPC_W+DATA_W-1:0]   instr_q;
    logic                      carry_q, carry_d;
    logic [1:0]                dest_q;
    logic [1:0]                src_q;
    logic                      fetch_q;
    logic                      busy_q;
    logic [OPC_W-1:0]          dec_op;
    logic                      take_jmp;
    dec_t                      dec;

    // In FETCH the decoder looks at the incoming ROM word so src_sel is ready in DECODE.
    assign dec_op = (state_q == S_FETCH) ? instr[OPC_W+DATA_W-1 -: OPC_W]
                                         : instr_q[OPC_W+DATA_W-1 -: OPC_W];

    reg_select_sequencer_opcode_field_decode u_opcode_field_decode (
        .opcode_i (dec_op),
        .dec_o    (dec)
    );

    always_comb begin
        take_jmp = dec.is_jmp && !(dec.is_jnc && carry_q);
        pc_d     = take_jmp ? PC_W'(instr_q[DATA_W-1:0]) : pc_q + PC_W'(1);
        carry_d  = dec.is_add ? alu_carry : dec.is_jnc ? 1'b0 : carry_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            carry_q <= 1'b0;
            dest_q  <= DEST_NONE;
            src_q   <= SRC_ZERO;
            fetch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        fetch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        state_q <= S_DECODE;
                        instr_q <= instr;
                        src_q   <= dec.src;
                        fetch_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                    dest_q  <= dec.dest;
                end
                S_EXEC: begin
                    state_q <= run ? S_FETCH : S_IDLE;
                    dest_q  <= DEST_NONE;
                    pc_q    <= pc_d;
                    carry_q <= carry_d;
                    fetch_q <= run;
                    busy_q  <= run;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_addr   = pc_q;
    assign fetch_req = fetch_q;
    assign {D1, D0}  = dest_q;
    assign src_sel   = src_q;
    assign imm       = instr_q[DATA_W-1:0];
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// tb_reg_select_sequencer: directed self-checking bench for reg_select_sequencer
module tb_reg_select_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] pc_addr;
    logic       fetch_req;
    logic [7:0] instr;
    logic       instr_valid;
    logic       alu_carry;
    logic       D1, D0;
    logic [1:0] src_sel;
    logic [3:0] imm;
    logic       busy;
    logic [7:0] rom [16];
    int         n_run = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign instr = rom[pc_addr];

    reg_select_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_addr     (pc_addr),
        .fetch_req   (fetch_req),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_carry   (alu_carry),
        .D1          (D1),
        .D0          (D0),
        .src_sel     (src_sel),
        .imm         (imm),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_pc [4];
`ifdef JMP_INSTR_EN
        exp_pc = '{9, 10, 7, 4};
`else
        exp_pc = '{3, 4, 5, 6};
`endif
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        reset = 1'b1;
        run = 1'b0;
        instr_valid = 1'b0;
        alu_carry = 1'b0;
        tick(2);
        chk("rst_pc", pc_addr, 0);
        chk("rst_fetch", fetch_req, 0);
        chk("rst_d", {D1, D0}, 3);
        chk("rst_src", src_sel, 3);
        chk("rst_imm", imm, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("idle_stays", busy, 0);

        rom[0] = 8'h35;
        run = 1'b1;
        instr_valid = 1'b1;
        tick();
        chk("t2_fetch_req", fetch_req, 1);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_dec_src", src_sel, 3);
        chk("t2_dec_imm", imm, 5);
        chk("t2_dec_d", {D1, D0}, 3);
        tick();
        chk("t2_exec_d", {D1, D0}, 0);
        run = 1'b0;
        tick();
        chk("t2_after_d", {D1, D0}, 3);
        chk("t2_pc", pc_addr, 1);
        chk("t2_idle_busy", busy, 0);

        rom[1] = 8'h47;
        instr_valid = 1'b0;
        run = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_wait_fetch", fetch_req, 1);
            chk("t3_wait_d", {D1, D0}, 3);
            chk("t3_wait_pc", pc_addr, 1);
            if (i < 4) tick();
        end
        instr_valid = 1'b1;
        tick();
        chk("t3_dec_src", src_sel, 0);
        chk("t3_dec_imm", imm, 7);
        chk("t3_dec_fetch", fetch_req, 0);
        run = 1'b0;
        tick();
        chk("t3_exec_d", {D1, D0}, 1);
        chk("t3_exec_busy", busy, 1);
        tick();
        chk("t3_idle_busy", busy, 0);
        chk("t3_pc_once", pc_addr, 2);

        rom[15] = 8'h9A;
        run = 1'b1;
        tick();
        tick(39);
        chk("t4_pc15", pc_addr, 15);
        chk("t4_fetch", fetch_req, 1);
        tick();
        chk("t4_dec_src", src_sel, 1);
        chk("t4_dec_imm", imm, 10);
        run = 1'b0;
        tick();
        chk("t4_exec_d", {D1, D0}, 2);
        tick();
        chk("t4_pc_wrap", pc_addr, 0);

        rom[1] = 8'h3C;
        run = 1'b1;
        tick();
        tick(3);
        tick(2);
        chk("t5_exec_d", {D1, D0}, 0);
        chk("t5_exec_pc", pc_addr, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_d", {D1, D0}, 3);
        chk("t5_async_pc", pc_addr, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_fetch", fetch_req, 0);
        #1 reset = 1'b0;
        run = 1'b0;
        tick();

        rom[0] = 8'h0F;
        rom[1] = 8'hE7;
        rom[2] = 8'hE9;
        rom[9] = 8'h0F;
        rom[10] = 8'hE7;
        rom[7] = 8'hF4;
        run = 1'b1;
        alu_carry = 1'b1;
        tick();
        tick(3);
        chk("t6_after_add", pc_addr, 1);
        alu_carry = 1'b0;
        tick(2);
        chk("t6_jnc_d", {D1, D0}, 3);
        tick();
        chk("t6_jnc_carry", pc_addr, 2);
        for (int i = 0; i < 4; i++) begin
            tick(3);
            chk($sformatf("t6_pc_%0d", i), pc_addr, exp_pc[i]);
        end
        run = 1'b0;
        tick(3);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_d", {D1, D0}, 3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
